// File: rtl/soc_mem_pkg.sv
// Shared types and address decode for the multi-master SRAM arbiter.
// Define SOC_MEM_ARB_INTERLEAVE_EN to word-interleave the banks instead of stacking them.
package soc_mem_pkg;

    localparam int unsigned BANK_IDX_MAX = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [BANK_IDX_MAX-1:0] bank;
        logic                    err;
        logic                    we;
    } rsp_entry_t;

    typedef struct packed {
        logic        oor;
        logic [31:0] bank;
        logic [31:0] word;
    } dec_t;

    function automatic dec_t addr_decode(input logic [31:0] addr, input int unsigned bank_bits,
                                         input int unsigned bank_aw);
        dec_t        d;
        logic [31:0] waddr;
        logic [31:0] wmask;
        logic [31:0] bmask;
        waddr = addr >> 2;
        wmask = (32'd1 << bank_aw) - 32'd1;
        bmask = (32'd1 << bank_bits) - 32'd1;
`ifdef SOC_MEM_ARB_INTERLEAVE_EN
        d.bank = waddr & bmask;
        d.word = (waddr >> bank_bits) & wmask;
`else
        d.word = waddr & wmask;
        d.bank = (waddr >> bank_aw) & bmask;
`endif
        d.oor = (waddr >> (bank_aw + bank_bits)) != 32'd0;
        return d;
    endfunction

endpackage

// File: rtl/soc_mem_arbiter_rr.sv
// Round-robin arbiter: one-hot grant from a request vector, pointer advances past the winner.
module soc_rr_arbiter
    import soc_mem_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] gnt
);

    localparam int unsigned PW = idx_width(NUM_MASTERS);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        ptr_d = ptr_q;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = (32'(ptr_q) + i) % NUM_MASTERS;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = (idx == NUM_MASTERS - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/soc_mem_arbiter.sv
// Multi-master, multi-bank SRAM arbiter with local grant/rvalid/rdata/err generation.
// Bank layout selected by SOC_MEM_ARB_INTERLEAVE_EN (see soc_mem_pkg).
module soc_mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 2,
    parameter int unsigned NUM_BANKS    = 2,
    parameter int unsigned BANK_AW      = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SRAM_LATENCY = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_MASTERS-1:0]                m_req,
    input  logic [NUM_MASTERS-1:0]                m_we,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_be,
    input  logic [NUM_MASTERS*32-1:0]             m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata,
    output logic [NUM_MASTERS-1:0]                m_gnt,
    output logic [NUM_MASTERS-1:0]                m_rvalid,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_rdata,
    output logic [NUM_MASTERS-1:0]                m_err,
    output logic [NUM_BANKS-1:0]                  bank_csb,
    output logic [NUM_BANKS-1:0]                  bank_web,
    output logic [NUM_BANKS*DATA_WIDTH/8-1:0]     bank_wmask,
    output logic [NUM_BANKS*BANK_AW-1:0]          bank_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]       bank_din,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]       bank_dout
);

    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
    localparam int unsigned BE_W      = DATA_WIDTH / 8;

    dec_t                   dec      [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] bank_req [NUM_BANKS];
    logic [NUM_MASTERS-1:0] bank_gnt [NUM_BANKS];
    rsp_entry_t             pipe_q   [NUM_MASTERS][SRAM_LATENCY];

    always_comb begin
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            dec[m] = addr_decode(m_addr[m*32 +: 32], BANK_BITS, BANK_AW);
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_req[b] = '0;
            for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
                bank_req[b][m] = m_req[m] & ~reset & ~dec[m].oor & (dec[m].bank == 32'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        soc_rr_arbiter #(
            .NUM_MASTERS(NUM_MASTERS)
        ) u_arb (
            .clk  (clk),
            .reset(reset),
            .req  (bank_req[b]),
            .gnt  (bank_gnt[b])
        );
    end

    // Out-of-range requests touch no bank and cannot conflict, so they bypass arbitration.
    always_comb begin
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            m_gnt[m] = m_req[m] & ~reset & dec[m].oor;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                m_gnt[m] = m_gnt[m] | bank_gnt[b][m];
            end
        end
    end

    always_comb begin
        bank_csb   = '1;
        bank_web   = '1;
        bank_wmask = '0;
        bank_addr  = '0;
        bank_din   = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
                if (bank_gnt[b][m]) begin
                    bank_csb[b]                       = 1'b0;
                    bank_web[b]                       = ~m_we[m];
                    bank_wmask[b*BE_W +: BE_W]        = m_be[m*BE_W +: BE_W];
                    bank_addr[b*BANK_AW +: BANK_AW]   = dec[m].word[BANK_AW-1:0];
                    bank_din[b*DATA_WIDTH +: DATA_WIDTH] = m_wdata[m*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
                for (int unsigned k = 0; k < SRAM_LATENCY; k++) begin
                    pipe_q[m][k] <= '0;
                end
            end
        end else begin
            for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
                pipe_q[m][0] <= '{valid: m_gnt[m], bank: BANK_IDX_MAX'(dec[m].bank),
                                  err: dec[m].oor, we: m_we[m]};
                for (int unsigned k = 1; k < SRAM_LATENCY; k++) begin
                    pipe_q[m][k] <= pipe_q[m][k-1];
                end
            end
        end
    end

    // Outputs are forced to their reset values while reset is held, hiding in-flight responses.
    always_comb begin
        for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
            m_rvalid[m] = pipe_q[m][SRAM_LATENCY-1].valid & ~reset;
            m_err[m]    = pipe_q[m][SRAM_LATENCY-1].valid & pipe_q[m][SRAM_LATENCY-1].err & ~reset;
            m_rdata[m*DATA_WIDTH +: DATA_WIDTH] = '0;
            if (m_rvalid[m] && !pipe_q[m][SRAM_LATENCY-1].err && !pipe_q[m][SRAM_LATENCY-1].we) begin
                m_rdata[m*DATA_WIDTH +: DATA_WIDTH] =
                    bank_dout[int'(pipe_q[m][SRAM_LATENCY-1].bank)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
